// File: rtl/life_pattern_editor.sv
// life_pattern_editor: cursor-driven editor for the life grid seed pattern.
// Board keys move a wrapping cursor and toggle/clear cells while gameState=0.
// Also produces a blinking one-hot cursor overlay for the display path.
// Build option: define LIFE_EDITOR_KEY_REPEAT_EN to auto-repeat held direction keys
// (adds REPEAT_DELAY / REPEAT_RATE parameters).
module life_pattern_editor #(
    parameter int unsigned GRID_SIZE    = 16,
    parameter int unsigned BLINK_CYCLES = 25000000
`ifdef LIFE_EDITOR_KEY_REPEAT_EN
    ,
    parameter int unsigned REPEAT_DELAY = 25000000,
    parameter int unsigned REPEAT_RATE  = 5000000
`endif
) (
    input  logic                                clk,
    input  logic                                reset_n,
    input  logic                                gameState,
    input  logic                                keyUp,
    input  logic                                keyDown,
    input  logic                                keyLeft,
    input  logic                                keyRight,
    input  logic                                keyToggle,
    input  logic                                keyClear,
    output logic [GRID_SIZE-1:0][GRID_SIZE-1:0] userInput,
    output logic [GRID_SIZE-1:0][GRID_SIZE-1:0] cursorMask,
    output logic [$clog2(GRID_SIZE)-1:0]        cursorRow,
    output logic [$clog2(GRID_SIZE)-1:0]        cursorCol
);

    localparam int unsigned CW = $clog2(GRID_SIZE);
    localparam int unsigned BW = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
    localparam int unsigned NK = 6;

    // Key bit positions inside the key vectors
    localparam int unsigned K_UP     = 0;
    localparam int unsigned K_DOWN   = 1;
    localparam int unsigned K_LEFT   = 2;
    localparam int unsigned K_RIGHT  = 3;
    localparam int unsigned K_TOGGLE = 4;
    localparam int unsigned K_CLEAR  = 5;

    localparam logic [CW-1:0] MAX_IDX    = CW'(GRID_SIZE - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_CYCLES - 1);

    logic [NK-1:0]                       keys;
    logic [NK-1:0]                       key_cur;
    logic [NK-1:0]                       key_prev;
    logic [NK-1:0]                       key_armed;
    logic [NK-1:0]                       press;
    logic [NK-1:0]                       evt;
    logic [GRID_SIZE-1:0][GRID_SIZE-1:0] pattern_d;
    logic [GRID_SIZE-1:0][GRID_SIZE-1:0] mask_d;
    logic [CW-1:0]                       row_d;
    logic [CW-1:0]                       col_d;
    logic [BW-1:0]                       blink_cnt;
    logic                                blink_on;

    assign keys = {keyClear, keyToggle, keyRight, keyLeft, keyDown, keyUp};

    // Sample keys and keep one cycle of history; runs in every game state.
    // A key is armed only after it has been seen low, so one held through reset never fires.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            key_cur   <= '0;
            key_prev  <= '0;
            key_armed <= '0;
        end else begin
            key_cur   <= keys;
            key_prev  <= key_cur;
            key_armed <= key_armed | ~keys;
        end
    end

    assign press = key_cur & ~key_prev & key_armed;

`ifdef LIFE_EDITOR_KEY_REPEAT_EN
    localparam int unsigned   HW        = $clog2(REPEAT_DELAY + REPEAT_RATE + 1);
    localparam logic [HW-1:0] HOLD_FIRE = HW'(REPEAT_DELAY);
    localparam logic [HW-1:0] HOLD_LAST = HW'(REPEAT_DELAY + REPEAT_RATE - 1);

    logic [3:0][HW-1:0] hold_cnt;
    logic [3:0]         rep_evt;

    // Cycles since each direction key was pressed; after the first repeat the count
    // loops over REPEAT_DELAY..REPEAT_DELAY+REPEAT_RATE-1, and release zeroes it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hold_cnt <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (!(key_cur[i] && key_armed[i])) begin
                    hold_cnt[i] <= '0;
                end else if (hold_cnt[i] == HOLD_LAST) begin
                    hold_cnt[i] <= HOLD_FIRE;
                end else begin
                    hold_cnt[i] <= hold_cnt[i] + 1'b1;
                end
            end
        end
    end

    // Synthetic direction events each time a held key's count lands on REPEAT_DELAY.
    always_comb begin
        rep_evt = '0;
        for (int i = 0; i < 4; i++) begin
            rep_evt[i] = key_cur[i] & key_prev[i] & key_armed[i] & (hold_cnt[i] == HOLD_FIRE);
        end
    end

    assign evt = press | {2'b00, rep_evt};
`else
    assign evt = press;
`endif

    // Next pattern and cursor from this cycle's events; everything holds while running.
    always_comb begin
        pattern_d = userInput;
        row_d     = cursorRow;
        col_d     = cursorCol;
        if (!gameState) begin
            // Toggle uses the pre-move cursor; clear overrides toggle.
            if (evt[K_CLEAR]) begin
                pattern_d = '0;
            end else if (evt[K_TOGGLE]) begin
                pattern_d[cursorRow][cursorCol] = ~userInput[cursorRow][cursorCol];
            end
            if (evt[K_UP] && !evt[K_DOWN]) begin
                row_d = (cursorRow == '0) ? MAX_IDX : cursorRow - 1'b1;
            end else if (evt[K_DOWN] && !evt[K_UP]) begin
                row_d = (cursorRow == MAX_IDX) ? '0 : cursorRow + 1'b1;
            end
            if (evt[K_LEFT] && !evt[K_RIGHT]) begin
                col_d = (cursorCol == '0) ? MAX_IDX : cursorCol - 1'b1;
            end else if (evt[K_RIGHT] && !evt[K_LEFT]) begin
                col_d = (cursorCol == MAX_IDX) ? '0 : cursorCol + 1'b1;
            end
        end
    end

    // Register the pattern and cursor.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            userInput <= '0;
            cursorRow <= '0;
            cursorCol <= '0;
        end else begin
            userInput <= pattern_d;
            cursorRow <= row_d;
            cursorCol <= col_d;
        end
    end

    // Free-running blink counter; the phase flips each time the counter wraps.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            blink_cnt <= '0;
            blink_on  <= 1'b1;
        end else if (blink_cnt == BLINK_LAST) begin
            blink_cnt <= '0;
            blink_on  <= ~blink_on;
        end else begin
            blink_cnt <= blink_cnt + 1'b1;
        end
    end

    // Overlay bit at the cursor, shown only in setup mode during the on phase.
    always_comb begin
        mask_d = '0;
        if (!gameState && blink_on) begin
            mask_d[cursorRow][cursorCol] = 1'b1;
        end
    end

    // Register the overlay; it trails the cursor registers by one cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cursorMask <= '0;
        end else begin
            cursorMask <= mask_d;
        end
    end

endmodule

// File: tb/tb_life_pattern_editor.sv
// Self-checking bench for life_pattern_editor: directed steps plus random key pulses
// compared against a per-press reference model of the editing rules.
`timescale 1ns/1ps
module tb_life_pattern_editor;

    localparam int G = 16;
    localparam int BLINK = 4;
    localparam int RDELAY = 8;
    localparam int RRATE = 3;

    localparam logic [5:0] KU = 6'b000001;
    localparam logic [5:0] KD = 6'b000010;
    localparam logic [5:0] KL = 6'b000100;
    localparam logic [5:0] KR = 6'b001000;
    localparam logic [5:0] KT = 6'b010000;
    localparam logic [5:0] KC = 6'b100000;

    logic clk = 1'b0;
    logic reset_n = 1'b1;
    logic gameState = 1'b0;
    logic keyUp = 1'b0, keyDown = 1'b0, keyLeft = 1'b0, keyRight = 1'b0;
    logic keyToggle = 1'b0, keyClear = 1'b0;
    logic [G-1:0][G-1:0] userInput;
    logic [G-1:0][G-1:0] cursorMask;
    logic [3:0] cursorRow;
    logic [3:0] cursorCol;

    // Reference model state
    bit mpat [G][G];
    int mrow, mcol;
    bit mgs;
    int edge_cnt;

    int total = 0;
    int passed = 0;
    int failed = 0;

    always #5 clk = ~clk;

    // Rising edges since the last reset release, used to predict the blink phase
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) edge_cnt <= 0;
        else edge_cnt <= edge_cnt + 1;
    end

    life_pattern_editor #(
        .GRID_SIZE(G),
        .BLINK_CYCLES(BLINK)
`ifdef LIFE_EDITOR_KEY_REPEAT_EN
        ,
        .REPEAT_DELAY(RDELAY),
        .REPEAT_RATE(RRATE)
`endif
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .gameState(gameState),
        .keyUp(keyUp),
        .keyDown(keyDown),
        .keyLeft(keyLeft),
        .keyRight(keyRight),
        .keyToggle(keyToggle),
        .keyClear(keyClear),
        .userInput(userInput),
        .cursorMask(cursorMask),
        .cursorRow(cursorRow),
        .cursorCol(cursorCol)
    );

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %h required %h", tag, obs, exp);
        end
    endtask

    task automatic set_keys(input logic [5:0] k);
        {keyClear, keyToggle, keyRight, keyLeft, keyDown, keyUp} = k;
    endtask

    function automatic logic [255:0] pat_vec();
        logic [G-1:0][G-1:0] v;
        for (int r = 0; r < G; r++)
            for (int c = 0; c < G; c++)
                v[r][c] = mpat[r][c];
        return v;
    endfunction

    function automatic logic [255:0] onehot_vec(input int r, input int c);
        logic [G-1:0][G-1:0] v;
        v = '0;
        v[r][c] = 1'b1;
        return v;
    endfunction

    task automatic model_clear();
        for (int r = 0; r < G; r++)
            for (int c = 0; c < G; c++)
                mpat[r][c] = 1'b0;
    endtask

    // One key event set, following the editing rules directly
    task automatic model_apply(input logic [5:0] k);
        if (mgs) return;
        if (k[5]) model_clear();
        else if (k[4]) mpat[mrow][mcol] = !mpat[mrow][mcol];
        mrow = (mrow + int'(k[1]) - int'(k[0]) + G) % G;
        mcol = (mcol + int'(k[3]) - int'(k[2]) + G) % G;
    endtask

    // Raise keys for one cycle, then let the edit settle
    task automatic pulse(input logic [5:0] k);
        @(negedge clk);
        set_keys(k);
        gameState = mgs;
        @(negedge clk);
        set_keys(6'b0);
        repeat (2) @(negedge clk);
        model_apply(k);
    endtask

    task automatic check_all(input string tag);
        bit on;
        on = !mgs && ((((edge_cnt - 1) / BLINK) % 2) == 0);
        check({tag, ".pattern"}, userInput, pat_vec());
        check({tag, ".row"}, 256'(cursorRow), 256'(mrow));
        check({tag, ".col"}, 256'(cursorCol), 256'(mcol));
        check({tag, ".mask"}, cursorMask, on ? onehot_vec(mrow, mcol) : 256'(0));
    endtask

    task automatic do_reset(input bit hold_toggle);
        @(negedge clk);
        set_keys(hold_toggle ? KT : 6'b0);
        mgs = 1'b0;
        gameState = 1'b0;
        #1 reset_n = 1'b0;
        #1;
        // Still before the next rising edge: reset must act without a clock
        check("reset.pattern", userInput, 256'(0));
        check("reset.row", 256'(cursorRow), 256'(0));
        check("reset.col", 256'(cursorCol), 256'(0));
        check("reset.mask", cursorMask, 256'(0));
        model_clear();
        mrow = 0;
        mcol = 0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        if (hold_toggle) begin
            check("held_thru_reset.pattern", userInput, 256'(0));
            set_keys(6'b0);
            repeat (2) @(negedge clk);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout required finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [5:0] k;
        int hold;
        int events;

        do_reset(1'b1);
        check_all("after_reset");

        pulse(KT);
        check_all("toggle_origin");
        pulse(KU);
        check_all("wrap_up");
        pulse(KL);
        check_all("wrap_left");
        pulse(KD);
        check_all("wrap_down");
        pulse(KR);
        check_all("wrap_right");

        repeat (3) pulse(KD);
        repeat (4) pulse(KR);
        check_all("at_3_4");
        pulse(KT | KR);
        check_all("toggle_with_right");
        pulse(KU | KD);
        check_all("up_down_cancel");
        pulse(KL | KR | KD);
        check_all("left_right_cancel");

        // Cursor now (4,5): one more down, set (5,5), then clear+toggle
        pulse(KD);
        pulse(KT);
        check_all("set_5_5");
        pulse(KC | KT);
        check_all("clear_beats_toggle");
        pulse(KT);
        pulse(KC | KU | KL);
        check_all("clear_with_move");

        // Running: every key ignored, overlay dark
        mgs = 1'b1;
        for (int i = 0; i < 6; i++) begin
            pulse(6'(1 << i));
            check_all($sformatf("run_key%0d", i));
        end

        // Toggle held across run->setup must not fire until re-pressed
        @(negedge clk);
        set_keys(KT);
        repeat (3) @(negedge clk);
        mgs = 1'b0;
        gameState = 1'b0;
        repeat (3) @(negedge clk);
        check_all("toggle_held_across_run");
        set_keys(6'b0);
        repeat (2) @(negedge clk);
        check_all("toggle_released");
        pulse(KT);
        check_all("toggle_repressed");

        // Random key combinations in random game states
        for (int i = 0; i < 40; i++) begin
            k = 6'($urandom_range(0, 63));
            if (k[5] && ($urandom_range(0, 2) != 0)) k[5] = 1'b0;
            mgs = ($urandom_range(0, 3) == 0);
            pulse(k);
            check_all($sformatf("rand%0d", i));
        end
        mgs = 1'b0;

        // Blink: cursor parked at (2,7), overlay checked every cycle
        do_reset(1'b0);
        repeat (2) pulse(KD);
        repeat (7) pulse(KR);
        check_all("blink_park");
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            check($sformatf("blink%0d", i), cursorMask,
                  ((((edge_cnt - 1) / BLINK) % 2) == 0) ? onehot_vec(2, 7) : 256'(0));
        end

`ifdef LIFE_EDITOR_KEY_REPEAT_EN
        // Hold right for 20 cycles from col 0: press, first repeat, then every RRATE cycles
        do_reset(1'b0);
        hold = 20;
        @(negedge clk);
        set_keys(KR);
        repeat (hold) @(negedge clk);
        set_keys(6'b0);
        repeat (3) @(negedge clk);
        events = 1;
        if (hold > RDELAY) events = events + 1 + (hold - 1 - RDELAY) / RRATE;
        mcol = (mcol + events) % G;
        check_all("repeat_right");

        // Toggle never repeats
        @(negedge clk);
        set_keys(KT);
        repeat (hold) @(negedge clk);
        set_keys(6'b0);
        repeat (3) @(negedge clk);
        mpat[mrow][mcol] = !mpat[mrow][mcol];
        check_all("toggle_no_repeat");
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/life_pattern_editor.md
Name: life_pattern_editor

Overview:
- Cursor-driven editor that builds the 16x16 seed pattern for the life grid.
- Its outputs drive the grid's userInput bus and a cursor overlay for the display path.
- Board keys move a cursor with toroidal wrap and toggle or clear cells.
- Edits are accepted only while the game is in setup mode.

Parameters:
GRID_SIZE, 16, grid edge length; pattern is GRID_SIZE x GRID_SIZE, cursor coordinates are $clog2(GRID_SIZE) bits
BLINK_CYCLES, 25000000, clk cycles per cursor-overlay blink half-period
REPEAT_DELAY, 25000000, cycles a direction key is held before auto-repeat starts (KEY_REPEAT_EN only)
REPEAT_RATE, 5000000, cycles between auto-repeat steps (KEY_REPEAT_EN only)

Ports:
clk  input  1  system clock
reset_n  input  1  asynchronous active-low reset
gameState  input  1  0 = setup (editing allowed), 1 = running (edits ignored)
keyUp  input  1  level, active-high, already synchronised; row-1
keyDown  input  1  row+1
keyLeft  input  1  col-1
keyRight  input  1  col+1
keyToggle  input  1  invert cell under cursor
keyClear  input  1  zero entire pattern
userInput  output  [GRID_SIZE-1:0][GRID_SIZE-1:0]  registered seed pattern, [row][col]
cursorMask  output  [GRID_SIZE-1:0][GRID_SIZE-1:0]  one-hot cursor overlay, registered
cursorRow  output  $clog2(GRID_SIZE)  current cursor row
cursorCol  output  $clog2(GRID_SIZE)  current cursor column

Behaviour:
- Reset (async, reset_n=0):
  - userInput = all 0; cursorRow = 0; cursorCol = 0.
  - cursorMask = all 0; blink counter = 0; blink phase = on.
  - Key history registers = 0, so a key held through reset release does not fire.
- Edge detection:
  - Each key has a previous-value register updated every cycle, including while gameState=1.
  - A press event = current 1 AND previous 0; one event per press.
- Events are acted on only when gameState=0. With gameState=1, events are discarded and userInput and the cursor hold.
- Edit latency: an event sampled at edge N updates userInput, cursorRow and cursorCol at edge N+1, visible the cycle after.
- Cursor movement:
  - Up: row = (row==0) ? GRID_SIZE-1 : row-1. Down: row = (row==GRID_SIZE-1) ? 0 : row+1.
  - Left and Right apply the same wrap to col.
- Simultaneous events in the same cycle:
  - Up+Down: no row change. Left+Right: no col change.
  - Row and col moves combine, giving a diagonal step.
  - Toggle with a move: toggle applies to the cell at the pre-move cursor.
  - Clear with Toggle: Clear wins, and the result is all zero.
  - Clear with a move: pattern cleared and cursor moves.
- Blink:
  - Free-running counter 0..BLINK_CYCLES-1; phase inverts on wrap.
  - Counter runs regardless of gameState.
- cursorMask:
  - Next-cycle value = one-hot at [cursorRow][cursorCol] when gameState=0 and phase=on, else all 0.
  - Lags the cursor registers by one cycle.
- gameState transition 0->1 mid-press: pattern is frozen as-is. No pending edits; all edits take effect within one cycle.
- Reset mid-operation: all state returns to reset values immediately, independent of clk.

Optional Feature:
- Macro: LIFE_EDITOR_KEY_REPEAT_EN.
- Defined:
  - Each direction key has a hold counter.
  - After the press event, if the key stays high for REPEAT_DELAY cycles, a synthetic event fires, then another every REPEAT_RATE cycles while held.
  - Releasing the key zeroes its counter.
  - Synthetic events follow all the same wrap and simultaneity rules.
  - Toggle and Clear never repeat.
- Undefined: no hold counters; one move per press only.

Test Plan:
- Reset, gameState=0, pulse keyToggle 1 cycle -> userInput[0][0]=1, all other cells 0; cursorRow=0, cursorCol=0.
- From (0,0): pulse keyUp, then keyLeft -> cursor (15,15); pulse keyDown -> (0,15); pulse keyRight -> (0,0).
- Cursor (3,4): keyToggle and keyRight rise same cycle -> userInput[3][4] inverted, [3][5] unchanged, cursor (3,5). keyUp+keyDown together -> cursor unchanged.
- Set cells (0,0) and (5,5), then raise keyClear and keyToggle together -> userInput all 0, cursor unchanged.
- gameState=1, pulse every key -> userInput, cursor unchanged, cursorMask all 0. Hold keyToggle across the 1->0 transition -> no toggle until it is released and pressed again.
- BLINK_CYCLES=4 override, gameState=0, cursor (2,7):
  - cursorMask[2][7] alternates 1/0 every 4 cycles; all other bits stay 0.
  - With LIFE_EDITOR_KEY_REPEAT_EN, REPEAT_DELAY=8, REPEAT_RATE=3: hold keyRight 20 cycles from col 0 -> col ends at 1+1+3 = 5.
